jt89: RTL and testbench

Clone of the SN76489 programmable sound generator: three square-wave tone channels and one LFSR noise channel, each with 4-bit logarithmic attenuation. The block is programmed through an 8-bit write-only bus and produces one signed 12-bit mixed sample. It sits between the CPU bus interface and the audio output/filter stage, in a single clock domain.

---
 rtl/jt89.sv | 185 ++++++++++++++++++
 tb/tb_jt89.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jt89.sv
// jt89: SN76489-compatible programmable sound generator.
// Three square-wave tone channels and one LFSR noise channel, each with 4-bit
// logarithmic attenuation. It is programmed through an 8-bit write-only bus and
// produces one registered, signed 12-bit mixed sample.
// Build option JT89_TI_LFSR_EN selects the 15-bit TI noise LFSR. When the macro
// is undefined, the 16-bit Sega LFSR is used.
module jt89 (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic               wr_n,
  input  logic [7:0]         din,
  output logic signed [11:0] sound
);

`ifdef JT89_TI_LFSR_EN
  localparam int                LFSR_W    = 15;
  localparam int                WHITE_TAP = 1;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h4000;
`else
  localparam int                LFSR_W    = 16;
  localparam int                WHITE_TAP = 3;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'h8000;
`endif

  // Register file
  logic [9:0]        period [3];
  logic [3:0]        att    [4];
  logic [2:0]        noise_ctrl;   // {FB, NF[1:0]}
  logic [2:0]        index;        // {channel[1:0], type}, type 1 = attenuation

  // Sound state
  logic [3:0]        presc;
  logic              tick;
  logic [9:0]        tone_cnt [3];
  logic [2:0]        tone_tgl;
  logic [2:0]        tone_out;
  logic [6:0]        noise_cnt;
  logic [6:0]        noise_reload;
  logic              noise_clk;
  logic              noise_src;
  logic              noise_src_d;
  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_fb;

  // Write decode: a latch byte carries its own index; a data byte uses the latched one.
  logic [2:0]        sel;
  logic              noise_wr;

  assign sel      = din[7] ? din[6:4] : index;
  assign noise_wr = !wr_n && (sel == 3'b110);
  assign tick     = clk_en && (presc == 4'hF);

  // Bus writes into the register file; these ignore clk_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the register arrays are plain flops rather than RAM, so every entry gets a reset value.
      for (int i = 0; i < 3; i++) period[i] <= '0;
      for (int i = 0; i < 4; i++) att[i]    <= 4'hF;
      noise_ctrl <= '0;
      index      <= '0;
    end else if (!wr_n) begin
      if (din[7]) index <= din[6:4];
      if (sel[0])                att[sel[2:1]]             <= din[3:0];
      else if (sel[2:1] == 2'd3) noise_ctrl                <= din[2:0];
      else if (din[7])           period[sel[2:1]][3:0]     <= din[3:0];
      else                       period[sel[2:1]][9:4]     <= din[5:0];
    end
  end

  // Prescaler: one tick every 16 enabled clocks.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst)         presc <= '0;
    else if (clk_en) presc <= presc + 4'd1;
  end

  // Tone counters: each level lasts 'period' ticks; the new period is picked up at reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) tone_cnt[i] <= '0;
      tone_tgl <= '0;
    end else if (tick) begin
      for (int i = 0; i < 3; i++) begin
        if (tone_cnt[i] <= 10'd1) begin
          tone_cnt[i] <= period[i];
          tone_tgl[i] <= ~tone_tgl[i];
        end else begin
          tone_cnt[i] <= tone_cnt[i] - 10'd1;
        end
      end
    end
  end

  // Tone output: periods 0 and 1 hold the output high instead of producing an audible tone.
  always_comb begin
    // NOTE: every always_comb output receives a default first, so no latches are inferred.
    tone_out = '0;
    for (int i = 0; i < 3; i++) tone_out[i] = tone_tgl[i] | (period[i] < 10'd2);
  end

  // Noise rate selection: NF=3 borrows tone2 as the noise clock.
  always_comb begin
    case (noise_ctrl[1:0])
      2'd1:    noise_reload = 7'd32;
      2'd2:    noise_reload = 7'd64;
      default: noise_reload = 7'd16;
    endcase
    noise_src = (noise_ctrl[1:0] == 2'd3) ? tone_out[2] : noise_clk;
    lfsr_fb   = noise_ctrl[2] ? (lfsr[0] ^ lfsr[WHITE_TAP]) : lfsr[0];
  end

  // Noise rate counter: toggles the internal noise clock every 16/32/64 ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      noise_cnt <= '0;
      noise_clk <= 1'b0;
    end else if (tick) begin
      if (noise_cnt <= 7'd1) begin
        noise_cnt <= noise_reload;
        noise_clk <= ~noise_clk;
      end else begin
        noise_cnt <= noise_cnt - 7'd1;
      end
    end
  end

  // LFSR: reseeds on any noise-control write; otherwise shifts on a rising noise-clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr        <= LFSR_SEED;
      noise_src_d <= 1'b0;
    end else begin
      if (clk_en) noise_src_d <= noise_src;
      if (noise_wr)
        lfsr <= LFSR_SEED;
      else if (clk_en && noise_src && !noise_src_d)
        lfsr <= {lfsr_fb, lfsr[LFSR_W-1:1]};
    end
  end

  // Logarithmic attenuation: 2 dB per step; 15 mutes the channel.
  function automatic logic [8:0] vol_lut(input logic [3:0] a);
    case (a)
      4'd0:    vol_lut = 9'd511;
      4'd1:    vol_lut = 9'd406;
      4'd2:    vol_lut = 9'd322;
      4'd3:    vol_lut = 9'd256;
      4'd4:    vol_lut = 9'd203;
      4'd5:    vol_lut = 9'd161;
      4'd6:    vol_lut = 9'd128;
      4'd7:    vol_lut = 9'd102;
      4'd8:    vol_lut = 9'd81;
      4'd9:    vol_lut = 9'd64;
      4'd10:   vol_lut = 9'd51;
      4'd11:   vol_lut = 9'd40;
      4'd12:   vol_lut = 9'd32;
      4'd13:   vol_lut = 9'd26;
      4'd14:   vol_lut = 9'd20;
      default: vol_lut = 9'd0;
    endcase
  endfunction

  logic [3:0]         ch_out;
  logic signed [9:0]  ch_val [4];
  logic signed [11:0] mix;

  // Mixer: each channel contributes +vol when high and -vol when low.
  always_comb begin
    ch_out = {lfsr[0], tone_out};
    mix    = '0;
    for (int i = 0; i < 4; i++) begin
      ch_val[i] = ch_out[i] ? $signed({1'b0, vol_lut(att[i])})
                            : -$signed({1'b0, vol_lut(att[i])});
      mix       = mix + {{2{ch_val[i][9]}}, ch_val[i]};
    end
  end

  // Output register, which trails the channel state by one enabled clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         sound <= '0;
    else if (clk_en) sound <= mix;
  end

endmodule

// File: tb/tb_jt89.sv
// Testbench for jt89. It compresses the sound output into runs of constant
// level and compares each completed run with an expected run that was queued
// when the stimulus was applied.
module tb_jt89;

`ifdef JT89_TI_LFSR_EN
  localparam int LW  = 15;
  localparam int TAP = 1;
`else
  localparam int LW  = 16;
  localparam int TAP = 3;
`endif

  logic               clk;
  logic               rst;
  logic               clk_en;
  logic               wr_n;
  logic [7:0]         din;
  logic signed [11:0] sound;

  int n_checks = 0;
  int n_err    = 0;
  bit en_div4  = 0;
  int en_phase = 0;

  typedef struct {
    string tag;
    int    val;
    int    len;
    bit    chk_val;
    bit    chk_abs;
    bit    chk_len;
  } run_t;

  run_t exp_q[$];

  jt89 dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .wr_n   (wr_n),
    .din    (din),
    .sound  (sound)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Clock-enable generator: either continuous or one cycle in four.
  initial begin
    clk_en = 1;
    forever begin
      @(negedge clk);
      if (en_div4) begin
        en_phase = (en_phase + 1) % 4;
        clk_en   = (en_phase == 0);
      end else begin
        clk_en = 1;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_run(input string tag, input int val, input int len,
                          input bit cv, input bit ca, input bit cl);
    run_t e;
    e.tag = tag; e.val = val; e.len = len;
    e.chk_val = cv; e.chk_abs = ca; e.chk_len = cl;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [7:0] b);
    @(negedge clk);
    din  = b;
    wr_n = 0;
    @(negedge clk);
    wr_n = 1;
  endtask

  // Waits for the next enabled edge and returns the number of clocks waited and the new sample.
  task automatic sample(output int waited, output int v);
    waited = 0;
    do begin
      @(posedge clk);
      waited++;
    end while (clk_en !== 1'b1);
    @(negedge clk);
    v = sound;
  endtask

  task automatic complete_run(input int v, input int len);
    run_t e;
    if (exp_q.size() == 0) begin
      check("extra_run", len, 0);
      return;
    end
    e = exp_q.pop_front();
    if (e.chk_val) check({e.tag, "_val"}, v, e.val);
    if (e.chk_abs) check({e.tag, "_mag"}, (v < 0) ? -v : v, e.val);
    if (e.chk_len) check({e.tag, "_len"}, len, e.len);
  endtask

  // Run lengths are measured in clk cycles. In flush mode the monitor watches
  // for max_clks, then closes the open run. Otherwise it stops once the queue is empty.
  task automatic run_monitor(input int max_clks, input bit flush);
    int cur, len, total, waited, v;
    sample(waited, v);
    cur = v; len = 0; total = 0;
    while (total < max_clks && (flush || exp_q.size() > 0)) begin
      sample(waited, v);
      total += waited;
      len   += waited;
      if (v != cur) begin
        complete_run(cur, len);
        cur = v;
        len = 0;
      end
    end
    if (flush) complete_run(cur, len);
    if (exp_q.size() != 0) begin
      check("runs_pending", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Reference white-noise LFSR. The leading run of zeros is only partly observed, so only its level is checked.
  task automatic push_noise(input string tag);
    int l, fb, cur, r, cum;
    bit lead;
    l = 1 << (LW - 1);
    push_run({tag, "_seed"}, -511, 0, 1, 0, 0);
    cur = l & 1; lead = 1; r = 0; cum = 0;
    for (int s = 0; s < 200 && cum < 12; s++) begin
      fb = (l & 1) ^ ((l >> TAP) & 1);
      l  = (l >> 1) | (fb << (LW - 1));
      if ((l & 1) == cur) begin
        r++;
      end else begin
        if (!lead) begin
          push_run({tag, "_run"}, (cur != 0) ? 511 : -511, r * 512, 1, 0, 1);
          cum += r;
        end
        lead = 0;
        cur  = l & 1;
        r    = 1;
      end
    end
  endtask

  initial begin
    rst  = 1;
    wr_n = 1;
    din  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_sound", sound, 0);
    rst = 0;

    // Idle after reset: silent
    push_run("idle", 0, 0, 1, 0, 0);
    run_monitor(300, 1);

    // Tone0 period 0x0FE at full volume
    wr(8'h8E); wr(8'h0F); wr(8'h90);
    repeat (2) @(negedge clk);
    push_run("tone_first", 0, 0, 0, 0, 0);
    repeat (2) push_run("tone511", 511, 254 * 16, 0, 1, 1);
    run_monitor(20000, 0);

    // Attenuation 4
    wr(8'h94);
    repeat (2) @(negedge clk);
    push_run("att4_first", 0, 0, 0, 0, 0);
    push_run("tone203", 203, 254 * 16, 0, 1, 1);
    run_monitor(12000, 0);

    // Mute
    wr(8'h9F);
    repeat (2) @(negedge clk);
    push_run("mute", 0, 0, 1, 0, 0);
    run_monitor(300, 1);

    // Period 1 holds the output high
    wr(8'h81); wr(8'h00); wr(8'h90);
    repeat (2) @(negedge clk);
    push_run("period1_dc", 511, 0, 1, 0, 0);
    run_monitor(300, 1);
    wr(8'h9F);

    // White noise, NF=0, full volume
    wr(8'hE4); wr(8'hF0);
    repeat (2) @(negedge clk);
    push_noise("noise");
    run_monitor(24000, 0);

    // Rewriting noise control restarts the sequence
    wr(8'hE4);
    repeat (2) @(negedge clk);
    push_noise("noise_rw");
    run_monitor(24000, 0);
    wr(8'hFF);

    // clk_en 1-in-4, with writes landing on disabled cycles; tone0 period 16
    en_div4 = 1;
    wr(8'h80); wr(8'h01); wr(8'h90);
    repeat (4) @(negedge clk);
    push_run("div4_first", 0, 0, 0, 0, 0);
    repeat (2) push_run("div4_tone", 511, 16 * 16 * 4, 0, 1, 1);
    run_monitor(5000, 0);

    // Asynchronous reset in mid-operation
    @(negedge clk);
    #3 rst = 1;
    #1 check("async_reset", sound, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst     = 0;
    en_div4 = 0;

    // After reset, period is 0 (DC high), so att0=0 yields constant +511
    wr(8'h90);
    repeat (2) @(negedge clk);
    push_run("post_reset_dc", 511, 0, 1, 0, 0);
    run_monitor(300, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
